// File: rtl/dcache_pkg.sv
// Shared sizing parameters and line layout for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned LINES     = 16;
  localparam int unsigned MEM_WORDS = 256;
  localparam int unsigned INDEX_W   = $clog2(LINES);
  localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);
  localparam int unsigned TAG_W     = WIDTH - 2 - INDEX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } line_t;

endpackage

// File: rtl/dcache_backing_mem.sv
// Word array behind the cache: synchronous write, combinational read, zero at power-up.
module dcache_backing_mem
  import dcache_pkg::*;
#(
  parameter int unsigned DW    = WIDTH,
  parameter int unsigned DEPTH = MEM_WORDS
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o
);

  // Power-up contents come from the declaration; there is deliberately no reset.
  logic [DW-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dcache.sv
// Single-cycle direct-mapped write-through, write-allocate data cache over a private memory.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned WIDTH     = dcache_pkg::WIDTH,
  parameter int unsigned LINES     = dcache_pkg::LINES,
  parameter int unsigned MEM_WORDS = dcache_pkg::MEM_WORDS
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] address,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read,
  input  logic             write,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned TW = WIDTH - 2 - IW;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [WIDTH-1:0] line_q [LINES];
  logic [WIDTH-1:0] data_out_q, data_out_d;

  logic [IW-1:0]    idx;
  logic [TW-1:0]    tag;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             hit, mem_we, line_we;
  logic [WIDTH-1:0] line_d;
  logic             unused_addr;

  assign idx         = address[IW+1:2];
  assign tag         = address[WIDTH-1:IW+2];
  assign mem_addr    = address[AW+1:2];
  assign unused_addr = ^address[1:0];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag);

  // Accesses seen while RST is high are dropped, including the memory write.
  always_comb begin
    mem_we     = 1'b0;
    line_we    = 1'b0;
    line_d     = data_in;
    data_out_d = data_out_q;
    if (!RST) begin
      if (write) begin
        mem_we  = 1'b1;
        line_we = 1'b1;
      end else if (read) begin
        if (hit) begin
          data_out_d = line_q[idx];
        end else begin
          data_out_d = mem_rdata;
          line_we    = 1'b1;
          line_d     = mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q    <= '0;
      data_out_q <= '0;
    end else begin
      if (line_we) valid_q[idx] <= 1'b1;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (line_we) begin
      tag_q[idx]  <= tag;
      line_q[idx] <= line_d;
    end
  end

  dcache_backing_mem #(
    .DW    (WIDTH),
    .DEPTH (MEM_WORDS)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (data_in),
    .rdata_o (mem_rdata)
  );

  assign data_out = data_out_q;

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache with hand-computed expected load results.
module tb_dcache;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] data_out;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  dcache dut (
    .CLK      (CLK),
    .RST      (RST),
    .address  (address),
    .data_in  (data_in),
    .read     (read),
    .write    (write),
    .data_out (data_out)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one access for exactly one rising edge, then return to idle.
  task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK);
    read = r; write = w; address = a; data_in = d;
    @(posedge CLK);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    op(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    op(1'b0, 1'b1, a, d);
  endtask

  initial begin
    #1;
    check_eq("reset_dout", data_out, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b0, 32'h4, 32'hFFFF_FFFF);
      check_eq("idle_dout", data_out, 32'h0);
    end

    wr(32'd4, 32'h11);
    check_eq("write_holds", data_out, 32'h0);
    rd(32'd4);
    check_eq("rd4_after_wr", data_out, 32'h11);

    wr(32'd8, 32'h12);
    wr(32'd8, 32'h22);
    rd(32'd8);
    check_eq("rd8_last_wins", data_out, 32'h22);
    rd(32'd12);
    check_eq("rd12_unwritten", data_out, 32'h0);
    rd(32'd16);
    check_eq("rd16_unwritten", data_out, 32'h0);

    wr(32'd4, 32'hAA);
    wr(32'd68, 32'hBB);
    rd(32'd4);
    check_eq("rd4_conflict_miss", data_out, 32'hAA);
    rd(32'd68);
    check_eq("rd68_conflict_miss", data_out, 32'hBB);
    rd(32'd4);
    check_eq("rd4_refill", data_out, 32'hAA);

    op(1'b1, 1'b1, 32'd20, 32'h55);
    check_eq("rw_holds", data_out, 32'hAA);
    rd(32'd20);
    check_eq("rd20_after_rw", data_out, 32'h55);
    rd(32'd21);
    check_eq("rd21_byte_bits", data_out, 32'h55);

    wr(32'd4, 32'h11);
    rd(32'd68);
    check_eq("rd68_pre_reset", data_out, 32'hBB);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_eq("async_reset_dout", data_out, 32'h0);
    write = 1'b1; address = 32'd4; data_in = 32'h99;
    @(posedge CLK);
    #1;
    write = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    rd(32'd4);
    check_eq("rd4_after_reset", data_out, 32'h11);
    rd(32'd4 + 32'd1024);
    check_eq("rd_alias_1028", data_out, 32'h11);
    rd(32'd68);
    check_eq("rd68_after_reset", data_out, 32'hBB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
